// File: rtl/fifo_reader.sv
// Two-entry skid buffer between a fifo head and a valid/ready consumer.
// Pop is issued without looking at out_ready; the skid register absorbs the extra entry.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | no entry held, out_valid low
// ST_ONE   | main holds the entry presented on out_data
// ST_TWO   | main presented, skid holds the next entry
module fifo_reader #(
    parameter int WIDTH = 16,
    parameter int DEBUG = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             q_empty,
    input  logic [WIDTH-1:0] q_data,
    output logic             pop,
    output logic             fifo_flush,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [15:0]      delivered,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_main_nxt;
    logic [WIDTH-1:0] w_skid_nxt;
    logic [15:0]      r_delivered;
    logic             w_pop;
    logic             w_deliver;

    assign out_valid  = (r_state != ST_EMPTY);
    assign w_deliver  = out_valid && out_ready;
    // rst_n is folded in so the fifo sees no pop while reset is held
    assign w_pop      = rst_n && !q_empty && !flush && (r_state != ST_TWO);
    assign pop        = w_pop;
    assign fifo_flush = flush;
    assign out_data   = r_main;
    assign delivered  = r_delivered;
    assign occupancy  = r_state;

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        case (r_state)
            ST_EMPTY: begin
                if (w_pop) begin
                    w_state_nxt = ST_ONE;
                    w_main_nxt  = q_data;
                end
            end
            ST_ONE: begin
                if (w_pop && w_deliver) begin
                    w_main_nxt = q_data;
                end else if (w_pop) begin
                    w_state_nxt = ST_TWO;
                    w_skid_nxt  = q_data;
                end else if (w_deliver) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_deliver) begin
                    w_state_nxt = ST_ONE;
                    w_main_nxt  = r_skid;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
        // flush wins over any pop or delivery in the same cycle
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            r_main <= w_main_nxt;
            r_skid <= w_skid_nxt;
        end
    end

    // a delivery in the flush cycle still reached the consumer, so it counts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_delivered <= '0;
        end else if (w_deliver) begin
            r_delivered <= r_delivered + 16'd1;
        end
    end

    generate
        if (DEBUG != 0) begin : g_debug
`ifndef SYNTHESIS
            always @(posedge clk) begin
                if (rst_n && w_deliver) begin
                    $display("fifo_reader: deliver 0x%0h at %0t", r_main, $time);
                end
                if (rst_n && flush) begin
                    $display("fifo_reader: flush at %0t", $time);
                end
            end
`endif
        end
    endgenerate

endmodule

// File: tb/tb_fifo_reader.sv
// Scoreboard bench for fifo_reader: a queue models the attached fifo, a second queue holds
// entries popped but not yet delivered, which is exactly what the buffer must contain.
module tb_fifo_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        q_empty;
    logic [15:0] q_data;
    logic        pop;
    logic        fifo_flush;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [15:0] delivered;
    logic [1:0]  occupancy;

    logic [15:0] fifo_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] d_model;
    logic        exp_pop;
    bit          mon_en;
    int          n_tests;
    int          n_fail;
    int          n_deliv;

    fifo_reader #(.WIDTH(16), .DEBUG(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .q_empty    (q_empty),
        .q_data     (q_data),
        .pop        (pop),
        .fifo_flush (fifo_flush),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .delivered  (delivered),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: judges each cycle just after the inputs settle, well before the rising edge.
    always @(negedge clk) begin
        #1;
        if (mon_en) begin
            exp_pop = !q_empty && !flush && (exp_q.size() < 2);
            chk("pop", {31'd0, pop}, {31'd0, exp_pop});
            chk("fifo_flush", {31'd0, fifo_flush}, {31'd0, flush});
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
            chk("occupancy", {30'd0, occupancy}, exp_q.size());
            chk("delivered", {16'd0, delivered}, {16'd0, d_model});
            if (exp_q.size() != 0) chk("out_data", {16'd0, out_data}, {16'd0, exp_q[0]});
            if (out_valid && out_ready) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                d_model = d_model + 16'd1;
                n_deliv++;
            end
            if (flush) exp_q.delete();
        end
    end

    // One stimulus cycle; the fifo model dequeues when the DUT pops.
    task automatic step(input bit fl, input bit rdy, input bit allow);
        @(negedge clk);
        flush     = fl;
        out_ready = rdy;
        q_empty   = (fifo_q.size() == 0) || !allow;
        q_data    = q_empty ? 16'($urandom) : fifo_q[0];
        #2;
        if (pop && !q_empty && fifo_q.size() != 0) begin
            exp_q.push_back(fifo_q[0]);
            void'(fifo_q.pop_front());
        end
        if (fifo_flush) fifo_q.delete();
    endtask

    // Reset asserted between clock edges; outputs must clear with no edge.
    task automatic do_reset();
        mon_en = 1'b0;
        @(negedge clk);
        flush     = 1'b0;
        out_ready = 1'b0;
        q_empty   = (fifo_q.size() == 0);
        q_data    = q_empty ? 16'h0 : fifo_q[0];
        #3 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {16'd0, out_data}, 32'd0);
        chk("rst_delivered", {16'd0, delivered}, 32'd0);
        chk("rst_occupancy", {30'd0, occupancy}, 32'd0);
        chk("rst_pop", {31'd0, pop}, 32'd0);
        @(negedge clk);
        q_empty = 1'b1;
        rst_n   = 1'b1;
        exp_q.delete();
        d_model = 16'd0;
        mon_en  = 1'b1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0; q_empty = 1'b1; q_data = 16'h0;
        mon_en = 1'b0; d_model = 16'd0; n_tests = 0; n_fail = 0; n_deliv = 0;
        do_reset();

        // three entries streamed with the consumer always ready
        fifo_q = '{16'h0001, 16'h0002, 16'h0003};
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1);
        chk("three_delivered", {16'd0, delivered}, 32'd3);

        // backpressure fills main and skid, then drains in order
        fifo_q = '{16'h00A1, 16'h00A2, 16'h00A3};
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
        chk("bp_occupancy", {30'd0, occupancy}, 32'd2);
        chk("bp_out_data", {16'd0, out_data}, 32'h00A1);
        chk("bp_pop_low", {31'd0, pop}, 32'd0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1);
        chk("bp_delivered", {16'd0, delivered}, 32'd6);

        // flush while full and not ready
        fifo_q = '{16'h00B1, 16'h00B2, 16'h00B3, 16'h00B4};
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("flush_fifo_flush", {31'd0, fifo_flush}, 32'd1);
        chk("flush_pop_low", {31'd0, pop}, 32'd0);
        step(1'b0, 1'b0, 1'b1);
        chk("post_flush_valid", {31'd0, out_valid}, 32'd0);
        chk("post_flush_occ", {30'd0, occupancy}, 32'd0);
        chk("post_flush_deliv", {16'd0, delivered}, 32'd6);

        // flush coinciding with a delivery still counts it
        fifo_q = '{16'h00C1, 16'h00C2, 16'h00C3};
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("flush_deliv_count", {16'd0, delivered}, 32'd7);

        // reset mid-stream with the fifo non-empty
        fifo_q = '{16'h00D1, 16'h00D2, 16'h00D3};
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b1);
        do_reset();

        // fifo empty flag toggling every cycle
        fifo_q.delete();
        for (int i = 0; i < 20; i++) fifo_q.push_back(16'($urandom));
        for (int i = 0; i < 45; i++) step(1'b0, 1'b1, (i % 2) == 0);

        // randomized traffic, readiness and occasional flushes
        for (int i = 0; i < 3000; i++) begin
            if (fifo_q.size() < 6 && $urandom_range(2) == 0) fifo_q.push_back(16'($urandom));
            step($urandom_range(39) == 0, $urandom_range(3) != 0, $urandom_range(2) != 0);
        end

        // counter wrap after 65537 deliveries
        do_reset();
        n_deliv = 0;
        for (int i = 0; i < 70000 && n_deliv < 65537; i++) begin
            while (fifo_q.size() < 4) fifo_q.push_back(16'($urandom));
            step(1'b0, 1'b1, 1'b1);
        end
        if (n_deliv != 65537) begin
            n_tests++;
            n_fail++;
            $display("FAIL wrap_budget: got %0d deliveries required 65537", n_deliv);
        end
        step(1'b0, 1'b0, 1'b0);
        chk("delivered_wrap", {16'd0, delivered}, 32'h0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning bits per entry; it SHALL match the WIDTH of the attached fifo.
REQ-002 SHALL have parameter DEBUG, default 0, meaning that when nonzero each delivery and each flush is $display'd.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port q_empty, input, 1 bit: empty flag from the fifo.
REQ-006 SHALL have port q_data, input, WIDTH bits: fifo head entry, valid whenever q_empty=0.
REQ-007 SHALL have port pop, output, 1 bit: dequeue request to the fifo, consumed at the same rising edge.
REQ-008 SHALL have port fifo_flush, output, 1 bit: flush request to the fifo.
REQ-009 SHALL have port flush, input, 1 bit: discard all buffered and queued entries.
REQ-010 SHALL have port out_valid, output, 1 bit: out_data holds a valid entry.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts out_data this cycle.
REQ-012 SHALL have port out_data, output, WIDTH bits: delivered entry.
REQ-013 SHALL have port delivered, output, 16 bits: count of completed deliveries.
REQ-014 SHALL have port occupancy, output, 2 bits: internal buffer state (0=EMPTY, 1=ONE, 2=TWO).

Function
REQ-015 SHALL hold entries in a main register and a skid register, tracked by a 3-state machine: EMPTY, ONE, TWO; encoding 3 is unreachable and SHALL recover to EMPTY.
REQ-016 SHALL define deliver = out_valid && out_ready; out_valid = (state != EMPTY); out_data = main register.
REQ-017 SHALL drive pop combinationally = rst_n && !q_empty && !flush && (state != TWO); pop SHALL never depend on out_ready.
REQ-018 SHALL, at an edge with pop=1, capture q_data (the same-cycle value) into the buffer.
REQ-019 EMPTY transitions: pop -> ONE with main<=q_data; otherwise stay in EMPTY.
REQ-020 ONE transitions: pop&&deliver -> ONE with main<=q_data; pop&&!deliver -> TWO with skid<=q_data; !pop&&deliver -> EMPTY; otherwise stay in ONE.
REQ-021 TWO transitions: deliver -> ONE with main<=skid; otherwise stay in TWO with main and skid held.
REQ-022 SHALL preserve fifo order exactly; no entry is dropped or duplicated except by flush.
REQ-023 SHALL have latency of one cycle: an entry popped at edge N is on out_data with out_valid=1 from just after edge N, when the buffer was EMPTY.
REQ-024 SHALL sustain one delivery per cycle when q_empty=0 and out_ready=1 continuously.
REQ-025 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-026 SHALL drive fifo_flush = flush combinationally.
REQ-027 SHALL, at an edge with flush=1, set state to EMPTY regardless of pop or deliver; register contents are don't-care afterwards.
REQ-028 SHALL, for a deliver occurring in the flush cycle, count that delivery in delivered.
REQ-029 SHALL increment delivered by 1 at each edge where deliver=1, wrapping from 0xFFFF to 0x0000.
REQ-030 SHALL drive occupancy from the state register.

Reset
REQ-031 SHALL, while rst_n=0, force immediately (without clk) state=EMPTY, main=0, skid=0, delivered=0; hence out_valid=0, out_data=0, occupancy=0, pop=0.
REQ-032 SHALL, on rst_n deassertion, resume normal operation at the first following rising edge.

Verification
REQ-033 Reset; fifo holds 0x0001,0x0002,0x0003; out_ready=1 -> out_data 0x0001,0x0002,0x0003 on three consecutive cycles, then out_valid=0; delivered=3.
REQ-034 out_ready=0; fifo holds 0x00A1,0x00A2,0x00A3 -> pop high two cycles then low; occupancy=2; out_data=0x00A1 held; raise out_ready -> 0x00A1,0x00A2,0x00A3 in order, none lost.
REQ-035 In TWO, assert flush one cycle -> fifo_flush=1 and pop=0 that cycle; next cycle out_valid=0, occupancy=0; delivered unchanged if out_ready=0.
REQ-036 Perform 65537 deliveries -> delivered=0x0001.
REQ-037 Drop rst_n mid-stream between clock edges -> out_valid=0, out_data=0, delivered=0, pop=0 with no clk edge.
REQ-038 q_empty alternates 0/1 each cycle, out_ready=1 -> every pushed entry appears exactly once, in order, one cycle after its pop.
